// File: rtl/mem_echo_pkg.sv
// -----------------------------------------------------------------------------
// mem_echo_pkg
// Shared constants and types for the memory stream echo block.
//   WIDTH    : data word width
//   DEPTH    : buffer capacity in words
//   AW       : buffer address width
//   state_t  : controller state encoding (IDLE, LOAD, FETCH, DRAIN)
// -----------------------------------------------------------------------------
package mem_echo_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4096;
    localparam int AW    = $clog2(DEPTH);

    // Word counter is one bit wider than the address so it can hold DEPTH.
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FETCH,
        DRAIN
    } state_t;

endpackage : mem_echo_pkg

// File: rtl/mem_sp_sync.sv
// -----------------------------------------------------------------------------
// mem_sp_sync
// Single-port synchronous RAM, WIDTH x DEPTH, with a registered read.
// Read data for the address presented at edge N is visible after edge N.
//   clk    in   system clock
//   we     in   write enable; writes wdata to addr on the rising edge
//   addr   in   shared read/write address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_sp_sync #(
    parameter int WIDTH = mem_echo_pkg::WIDTH,
    parameter int DEPTH = mem_echo_pkg::DEPTH,
    parameter int AW    = mem_echo_pkg::AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset would stop it mapping
    // onto block RAM, and stale contents are never replayed anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule : mem_sp_sync

// File: rtl/mem_stream_echo.sv
// -----------------------------------------------------------------------------
// mem_stream_echo
// Captures one contiguous in_valid burst of words into an on-chip buffer and
// replays the same words, in order, as one contiguous out_valid burst of the
// same length. Bursts longer than DEPTH keep only the first DEPTH words.
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input word strobe; one burst is one contiguous high run
//   in_data    in   input word
//   out_valid  out  replay strobe (registered)
//   out_data   out  replayed word, zero whenever out_valid is low (registered)
// -----------------------------------------------------------------------------
module mem_stream_echo
    import mem_echo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    state_t           state;
    logic [AW:0]      cnt;      // words stored; counts down while draining
    logic [AW-1:0]    rd_ptr;   // next read address issued to the RAM

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    // Write port is used only while capturing; otherwise the address bus
    // carries the read pointer, so reads and writes never collide.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = rd_ptr;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = '0;
                end
            end
            LOAD: begin
                // Words past a full buffer are dropped, not wrapped.
                if (in_valid && (cnt < CNT_FULL)) begin
                    ram_we   = 1'b1;
                    ram_addr = cnt[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    mem_sp_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (in_data),
        .rdata (ram_rdata)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    if (in_valid) begin
                        cnt   <= CNT_ONE;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (in_valid) begin
                        if (cnt < CNT_FULL) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        rd_ptr <= '0;
                        state  <= FETCH;
                    end
                end

                // The RAM reads address 0 on this edge. Advancing the pointer
                // unconditionally is harmless for one-word bursts: the extra
                // read is never forwarded.
                FETCH: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    state  <= DRAIN;
                end

                // ram_rdata always holds the word for the current output slot;
                // the pointer runs one address ahead to hide the read latency.
                DRAIN: begin
                    if (cnt != '0) begin
                        out_valid <= 1'b1;
                        out_data  <= ram_rdata;
                        cnt       <= cnt - CNT_ONE;
                        rd_ptr    <= rd_ptr + AW'(1);
                    end else begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_stream_echo

// File: tb/tb_mem_stream_echo.sv
// -----------------------------------------------------------------------------
// tb_mem_stream_echo
// Self-checking bench for mem_stream_echo. Stimulus words go into stim_q; the
// reference expectation is simply the first min(N, DEPTH) words of the burst,
// replayed exactly three edges after the last input edge with no bubbles.
// -----------------------------------------------------------------------------
module tb_mem_stream_echo;
    import mem_echo_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] stim_q[$];

    mem_stream_echo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Drives stim_q as one burst, then follows the replay edge by edge.
    // With poke set, in_valid is held high (0x1234) on every edge from FETCH
    // through the edge that returns to IDLE; all of those must be ignored.
    task automatic run_burst(input string name, input bit poke);
        logic [WIDTH-1:0] exp_q[$];
        int n_exp;
        int first_c;
        int seen;
        bit done;
        bit zero_ok;

        n_exp = (stim_q.size() > DEPTH) ? DEPTH : stim_q.size();
        for (int i = 0; i < n_exp; i++) exp_q.push_back(stim_q[i]);

        foreach (stim_q[i]) begin
            in_valid = 1'b1;
            in_data  = stim_q[i];
            @(posedge clk); #1;
        end

        first_c = -1;
        seen    = 0;
        done    = 1'b0;
        zero_ok = 1'b1;
        for (int c = 1; c <= DEPTH + 20 && !done; c++) begin
            if (poke && c >= 2 && c <= n_exp + 3) begin
                in_valid = 1'b1;
                in_data  = 16'h1234;
            end else begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                if (seen < n_exp) begin
                    checks++;
                    if (out_data !== exp_q[seen]) begin
                        failures++;
                        $display("FAIL %s word[%0d]: got %h expected %h", name, seen, out_data, exp_q[seen]);
                    end
                end
                seen++;
            end else begin
                if (out_data !== '0) zero_ok = 1'b0;
                if (first_c >= 0) done = 1'b1;
            end
        end
        in_valid = 1'b0;

        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s end_of_replay: replay never completed within %0d cycles", name, DEPTH + 20);
        end
        checks++;
        if (first_c !== 3) begin
            failures++;
            $display("FAIL %s latency: first out_valid %0d edges after last input, expected 3", name, first_c);
        end
        checks++;
        if (seen !== n_exp) begin
            failures++;
            $display("FAIL %s length: got %0d words expected %0d", name, seen, n_exp);
        end
        checks++;
        if (zero_ok !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_data: out_data nonzero while out_valid low, expected 0", name);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset out_data: got %h expected 0000", out_data);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        begin
            int stray;
            stray = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b0) stray++;
            end
            checks++;
            if (stray != 0) begin
                failures++;
                $display("FAIL reset quiet: got %0d out_valid cycles expected 0", stray);
            end
        end
    endtask

    task automatic test_two_word();
        stim_q = '{16'd1024, 16'd512};
        run_burst("two_word", 1'b0);
    endtask

    task automatic test_single();
        stim_q = '{16'hBEEF};
        run_burst("single", 1'b0);
    endtask

    // Drain of {7,8,9} with in_valid poked, then {5} on the first IDLE edge.
    task automatic test_back_to_back();
        stim_q = '{16'd7, 16'd8, 16'd9};
        run_burst("ignore_in_drain", 1'b1);
        stim_q = '{16'd5};
        run_burst("back_to_back", 1'b0);
    endtask

    task automatic test_full();
        stim_q.delete();
        for (int i = 0; i < DEPTH; i++) stim_q.push_back(WIDTH'(i));
        run_burst("full", 1'b0);
    endtask

    task automatic test_overflow();
        stim_q.delete();
        for (int i = 0; i < DEPTH + 4; i++) stim_q.push_back(WIDTH'(i));
        run_burst("overflow", 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int stray;
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back(WIDTH'($urandom));
        foreach (stim_q[i]) begin
            in_valid = 1'b1;
            in_data  = stim_q[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        // Edge 5 after the last input is the third replay cycle.
        checks++;
        if (out_valid !== 1'b1 || out_data !== stim_q[2]) begin
            failures++;
            $display("FAIL mid_drain precheck: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, stim_q[2]);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_drain reset: got valid=%b data=%h expected valid=0 data=0000", out_valid, out_data);
        end
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL mid_drain quiet: got %0d out_valid cycles expected 0", stray);
        end
        stim_q = '{16'd3, 16'd4};
        run_burst("after_reset", 1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            int len;
            len = $urandom_range(1, 40);
            stim_q.delete();
            for (int i = 0; i < len; i++) stim_q.push_back(WIDTH'($urandom));
            run_burst($sformatf("random%0d", b), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_two_word();
        test_single();
        test_back_to_back();
        test_full();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_stream_echo
